mccpu: RTL and testbench

- Multi-cycle successor to the single-cycle MIPS-lite core.
- One shared instruction/data memory port with a req/ready handshake, so it tolerates wait states.
- Internal FSM sequences FETCH/DECODE/EXEC/MEM/WB; internal 32x32 register file and ALU.
- Same debug register read-out port as the single-cycle core; sits at SoC top in place of it.

---
 rtl/mccpu.sv | 212 +++++++++++++++++++++
 tb/tb_mccpu.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mccpu.sv
// mccpu: multi-cycle MIPS-lite core with one shared req/ready memory port and a debug register read-out.
// Optional macro MCCPU_PERF_EN adds the cycle_cnt/instret_cnt performance counters.
module mccpu #(
    parameter logic [31:0] RESET_PC      = 32'h0000_3000,
    parameter bit          MEM_ALIGN_CHK = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        trap,
    input  logic [4:0]  reg_sel,
`ifdef MCCPU_PERF_EN
    output logic [31:0] reg_data,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`else
    output logic [31:0] reg_data
`endif
);
    // state  | meaning
    // FETCH  | read instruction at pc, wait for ready
    // DECODE | latch rs/rt operands and extended immediate
    // EXEC   | ALU result, branch/jump pc update, alignment check
    // MEM    | lw/sw data access, wait for ready
    // WB     | register write, pc advance
    // TRAP   | fault, frozen until reset
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                           OP_ORI   = 6'h0D, OP_LUI  = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08,
                           F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25,
                           F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;

    state_t      state_q;
    logic [31:0] pc_q, ir_q, a_q, b_q, imm_q, alu_q, mdr_q;
    logic [31:0] rf_q [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, wb_dest;
    logic [31:0] imm_ext, alu_d, pc_inc, br_target, j_target, wb_data;
    logic        instr_ok, is_branch, is_jr, taken, misaligned;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign shamt = ir_q[10:6];
    assign funct = ir_q[5:0];

    always_comb begin
        instr_ok = 1'b0;
        if (op == OP_RTYPE) begin
            case (funct)
                F_SLL, F_SRL, F_SRA, F_JR, F_ADDU, F_SUBU,
                F_AND, F_OR, F_NOR, F_SLT, F_SLTU: instr_ok = 1'b1;
                default:                           instr_ok = 1'b0;
            endcase
        end else begin
            case (op)
                OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_SLTI,
                OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: instr_ok = 1'b1;
                default:                               instr_ok = 1'b0;
            endcase
        end
    end

    assign imm_ext = (op == OP_ANDI || op == OP_ORI) ? {16'h0000, ir_q[15:0]}
                                                     : {{16{ir_q[15]}}, ir_q[15:0]};

    always_comb begin
        alu_d = a_q + imm_q;
        if (op == OP_RTYPE) begin
            case (funct)
                F_ADDU:  alu_d = a_q + b_q;
                F_SUBU:  alu_d = a_q - b_q;
                F_AND:   alu_d = a_q & b_q;
                F_OR:    alu_d = a_q | b_q;
                F_NOR:   alu_d = ~(a_q | b_q);
                F_SLT:   alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
                F_SLTU:  alu_d = {31'd0, a_q < b_q};
                F_SLL:   alu_d = b_q << shamt;
                F_SRL:   alu_d = b_q >> shamt;
                F_SRA:   alu_d = $unsigned($signed(b_q) >>> shamt);
                default: alu_d = a_q + b_q;
            endcase
        end else begin
            case (op)
                OP_ANDI: alu_d = a_q & imm_q;
                OP_ORI:  alu_d = a_q | imm_q;
                OP_LUI:  alu_d = {ir_q[15:0], 16'h0000};
                OP_SLTI: alu_d = {31'd0, $signed(a_q) < $signed(imm_q)};
                OP_JAL:  alu_d = pc_inc;
                default: alu_d = a_q + imm_q;
            endcase
        end
    end

    assign pc_inc     = pc_q + 32'd4;
    assign br_target  = pc_inc + {imm_q[29:0], 2'b00};
    assign j_target   = {pc_inc[31:28], ir_q[25:0], 2'b00};
    assign is_branch  = (op == OP_BEQ) || (op == OP_BNE);
    assign is_jr      = (op == OP_RTYPE) && (funct == F_JR);
    assign taken      = (a_q == b_q) ^ (op == OP_BNE);
    assign misaligned = MEM_ALIGN_CHK && (alu_d[1:0] != 2'b00);
    assign wb_dest    = (op == OP_RTYPE) ? rd : (op == OP_JAL) ? 5'd31 : rt;
    assign wb_data    = (op == OP_LW) ? mdr_q : alu_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            case (state_q)
                S_FETCH: if (mem_ready) begin
                    ir_q    <= mem_rdata;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    a_q     <= rf_q[rs];
                    b_q     <= rf_q[rt];
                    imm_q   <= imm_ext;
                    state_q <= instr_ok ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    alu_q   <= alu_d;
                    state_q <= S_WB;
                    if (is_branch) begin
                        pc_q    <= taken ? br_target : pc_inc;
                        state_q <= S_FETCH;
                    end else if (op == OP_J) begin
                        pc_q    <= j_target;
                        state_q <= S_FETCH;
                    end else if (op == OP_JAL) begin
                        pc_q    <= j_target;
                    end else if (is_jr) begin
                        pc_q    <= a_q;
                        state_q <= S_FETCH;
                    end else if (op == OP_LW || op == OP_SW) begin
                        state_q <= misaligned ? S_TRAP : S_MEM;
                    end
                end
                S_MEM: if (mem_ready) begin
                    if (op == OP_LW) begin
                        mdr_q   <= mem_rdata;
                        state_q <= S_WB;
                    end else begin
                        pc_q    <= pc_inc;
                        state_q <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (wb_dest != 5'd0) rf_q[wb_dest] <= wb_data;
                    // jal already moved pc to its target in EXEC
                    if (op != OP_JAL) pc_q <= pc_inc;
                    state_q <= S_FETCH;
                end
                default: state_q <= S_TRAP;
            endcase
        end
    end

    assign mem_req   = !rst && (state_q == S_FETCH || state_q == S_MEM);
    assign mem_we    = !rst && (state_q == S_MEM) && (op == OP_SW);
    assign mem_addr  = (state_q == S_FETCH) ? pc_q : {alu_q[31:2], 2'b00};
    assign mem_wdata = b_q;
    assign pc        = pc_q;
    assign trap      = (state_q == S_TRAP);
    assign reg_data  = (reg_sel == 5'd0) ? 32'd0 : rf_q[reg_sel];

`ifdef MCCPU_PERF_EN
    logic        retire;
    logic [31:0] cycle_q, instret_q;

    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_EXEC:  retire = is_branch || (op == OP_J) || is_jr;
            S_MEM:   retire = mem_ready && (op == OP_SW);
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state_q != S_TRAP) cycle_q <= cycle_q + 32'd1;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif
endmodule

// File: tb/tb_mccpu.sv
// Directed bench for mccpu: behavioural memory with programmable wait states, hand-computed expectations.
module tb_mccpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, reg_data;
    logic [4:0]  reg_sel = 5'd0;
`ifdef MCCPU_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    logic [31:0] mem [0:4095];
    int          wait_n = 0;
    int          wcnt;
    int          we_xfer, we_pulse, stab_err = 0;
    logic [31:0] last_waddr, last_wdata;
    logic        hold_prev = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    mccpu dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .trap(trap), .reg_sel(reg_sel),
`ifdef MCCPU_PERF_EN
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
        .reg_data(reg_data)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[13:2]];
    assign mem_ready = mem_req && (wcnt == wait_n);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt     <= 0;
            we_xfer  <= 0;
            we_pulse <= 0;
        end else begin
            wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
            if (mem_we) we_pulse <= we_pulse + 1;
            if (mem_req && mem_ready && mem_we) begin
                we_xfer    <= we_xfer + 1;
                last_waddr <= mem_addr;
                last_wdata <= mem_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && hold_prev &&
            (!mem_req || mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
            stab_err <= stab_err + 1;
        hold_prev <= !rst && mem_req && !mem_ready;
        p_addr    <= mem_addr;
        p_we      <= mem_we;
        p_wdata   <= mem_wdata;
    end

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] ej(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    task automatic apply_reset(input int waits);
        @(negedge clk);
        rst    = 1'b1;
        wait_n = waits;
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset(3);
        mem['hC00] = ei(6'h09, 5'd0, 5'd1, 16'd5);
        reg_sel = 5'd1;
        #1;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req); else pass_cnt++;
        total_cnt++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_we); else pass_cnt++;
        total_cnt++; if (pc !== 32'h3000) $display("FAIL rst_pc: got %h want 00003000", pc); else pass_cnt++;
        total_cnt++; if (trap !== 1'b0) $display("FAIL rst_trap: got %b want 0", trap); else pass_cnt++;
        total_cnt++; if (reg_data !== 32'd0) $display("FAIL rst_r1: got %h want 0", reg_data); else pass_cnt++;
        release_reset();
        run(2);
        total_cnt++; if (mem_req !== 1'b1) $display("FAIL wait_req: got %b want 1", mem_req); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (mem_req !== 1'b0) $display("FAIL midrst_req: got %b want 0", mem_req); else pass_cnt++;
        // reset landing while addiu r1 is in WB must not commit the write
        wait_n = 0;
        release_reset();
        run(3);
        #1 rst = 1'b1;
        run(2);
        total_cnt++; if (reg_data !== 32'd0) $display("FAIL wbrst_r1: got %h want 0", reg_data); else pass_cnt++;
        release_reset();
        run(4);
        total_cnt++; if (reg_data !== 32'd5) $display("FAIL after_rst_r1: got %h want 5", reg_data); else pass_cnt++;
    endtask

    task automatic test_alu();
        logic [31:0] exp_r [18];
        int a;
        a = 'hC00;
        apply_reset(0);
        mem[a+0]  = ei(6'h09, 5'd0, 5'd1, 16'd5);
        mem[a+1]  = ei(6'h09, 5'd0, 5'd2, 16'hFFFD);
        mem[a+2]  = er(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
        mem[a+3]  = er(5'd1, 5'd2, 5'd4, 5'd0, 6'h23);
        mem[a+4]  = er(5'd2, 5'd1, 5'd5, 5'd0, 6'h2A);
        mem[a+5]  = er(5'd2, 5'd1, 5'd6, 5'd0, 6'h2B);
        mem[a+6]  = er(5'd0, 5'd2, 5'd7, 5'd1, 6'h03);
        mem[a+7]  = er(5'd0, 5'd2, 5'd8, 5'd28, 6'h02);
        mem[a+8]  = er(5'd0, 5'd1, 5'd9, 5'd4, 6'h00);
        mem[a+9]  = er(5'd1, 5'd0, 5'd10, 5'd0, 6'h27);
        mem[a+10] = ei(6'h0F, 5'd0, 5'd11, 16'h1234);
        mem[a+11] = ei(6'h0D, 5'd11, 5'd11, 16'h8001);
        mem[a+12] = ei(6'h0C, 5'd2, 5'd12, 16'hFFFF);
        mem[a+13] = ei(6'h0A, 5'd2, 5'd13, 16'd1);
        mem[a+14] = er(5'd2, 5'd1, 5'd14, 5'd0, 6'h24);
        mem[a+15] = er(5'd2, 5'd1, 5'd15, 5'd0, 6'h25);
        mem[a+16] = ei(6'h0A, 5'd1, 5'd16, 16'hFFFF);
        mem[a+17] = ei(6'h09, 5'd2, 5'd17, 16'd3);
        exp_r[0]  = 32'd0;        exp_r[1]  = 32'd5;        exp_r[2]  = 32'hFFFFFFFD;
        exp_r[3]  = 32'd2;        exp_r[4]  = 32'd8;        exp_r[5]  = 32'd1;
        exp_r[6]  = 32'd0;        exp_r[7]  = 32'hFFFFFFFE; exp_r[8]  = 32'hF;
        exp_r[9]  = 32'h50;       exp_r[10] = 32'hFFFFFFFA; exp_r[11] = 32'h12348001;
        exp_r[12] = 32'h0000FFFD; exp_r[13] = 32'd1;        exp_r[14] = 32'd5;
        exp_r[15] = 32'hFFFFFFFD; exp_r[16] = 32'd0;        exp_r[17] = 32'd0;
        reg_sel = 5'd3;
        release_reset();
        run(11);
        total_cnt++; if (pc !== 32'h3008) $display("FAIL alu_pc11: got %h want 00003008", pc); else pass_cnt++;
        run(1);
        total_cnt++; if (pc !== 32'h300C) $display("FAIL alu_pc12: got %h want 0000300c", pc); else pass_cnt++;
        total_cnt++; if (reg_data !== 32'd2) $display("FAIL alu_r3: got %h want 2", reg_data); else pass_cnt++;
        run(60);
        total_cnt++; if (pc !== 32'h3048) $display("FAIL alu_pc72: got %h want 00003048", pc); else pass_cnt++;
        for (int r = 1; r < 18; r++) begin
            @(negedge clk);
            reg_sel = 5'(r);
            #1;
            total_cnt++;
            if (reg_data !== exp_r[r]) $display("FAIL alu_r%0d: got %h want %h", r, reg_data, exp_r[r]);
            else pass_cnt++;
        end
    endtask

    task automatic test_wait_lw();
        apply_reset(3);
        mem[0]     = 32'hDEADBEEF;
        mem['hC00] = ei(6'h23, 5'd0, 5'd4, 16'd0);
        reg_sel = 5'd4;
        release_reset();
        run(7);
        total_cnt++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd0)
            $display("FAIL lw_memphase: got req=%b we=%b addr=%h want 1 0 00000000", mem_req, mem_we, mem_addr);
        else pass_cnt++;
        run(3);
        total_cnt++; if (reg_data !== 32'd0) $display("FAIL lw_r4_early: got %h want 0", reg_data); else pass_cnt++;
        run(1);
        total_cnt++; if (reg_data !== 32'hDEADBEEF) $display("FAIL lw_r4: got %h want deadbeef", reg_data); else pass_cnt++;
        total_cnt++; if (pc !== 32'h3004) $display("FAIL lw_pc: got %h want 00003004", pc); else pass_cnt++;
        run(6);
        total_cnt++; if (stab_err !== 0) $display("FAIL lw_stable: got %0d unstable cycles want 0", stab_err); else pass_cnt++;
    endtask

    task automatic test_branch();
        apply_reset(0);
        mem['hC00] = ei(6'h04, 5'd0, 5'd0, 16'hFFFF);
        release_reset();
        for (int k = 0; k < 3; k++) begin
            run(1);
            total_cnt++; if (mem_req !== 1'b0) $display("FAIL beq_decode%0d: got req=%b want 0", k, mem_req); else pass_cnt++;
            run(2);
            total_cnt++; if (pc !== 32'h3000 || mem_req !== 1'b1)
                $display("FAIL beq_loop%0d: got pc=%h req=%b want 00003000 1", k, pc, mem_req);
            else pass_cnt++;
        end
        apply_reset(0);
        mem['hC00] = ei(6'h05, 5'd0, 5'd0, 16'd4);
        release_reset();
        run(3);
        total_cnt++; if (pc !== 32'h3004) $display("FAIL bne_nt: got %h want 00003004", pc); else pass_cnt++;
        apply_reset(0);
        mem['hC00] = ei(6'h09, 5'd0, 5'd1, 16'd1);
        mem['hC01] = ei(6'h05, 5'd1, 5'd0, 16'd2);
        mem['hC04] = ei(6'h04, 5'd1, 5'd0, 16'd5);
        release_reset();
        run(7);
        total_cnt++; if (pc !== 32'h3010) $display("FAIL bne_taken: got %h want 00003010", pc); else pass_cnt++;
        run(3);
        total_cnt++; if (pc !== 32'h3014) $display("FAIL beq_nt: got %h want 00003014", pc); else pass_cnt++;
    endtask

    task automatic test_jal_jr();
        apply_reset(0);
        mem['hC00] = ej(6'h02, 32'h3010);
        mem['hC04] = ej(6'h03, 32'h3100);
        mem['hC40] = er(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        reg_sel = 5'd31;
        release_reset();
        run(3);
        total_cnt++; if (pc !== 32'h3010) $display("FAIL j_pc: got %h want 00003010", pc); else pass_cnt++;
        run(3);
        total_cnt++; if (pc !== 32'h3100 || reg_data !== 32'd0)
            $display("FAIL jal_exec: got pc=%h r31=%h want 00003100 00000000", pc, reg_data);
        else pass_cnt++;
        run(1);
        total_cnt++; if (pc !== 32'h3100 || reg_data !== 32'h3014)
            $display("FAIL jal_wb: got pc=%h r31=%h want 00003100 00003014", pc, reg_data);
        else pass_cnt++;
        run(3);
        total_cnt++; if (pc !== 32'h3014) $display("FAIL jr_pc: got %h want 00003014", pc); else pass_cnt++;
    endtask

    task automatic test_sw();
        apply_reset(1);
        mem['hC00] = ei(6'h09, 5'd0, 5'd1, 16'h0055);
        mem['hC01] = ei(6'h2B, 5'd0, 5'd1, 16'd4);
        release_reset();
        run(12);
        total_cnt++; if (pc !== 32'h3008) $display("FAIL sw_pc: got %h want 00003008", pc); else pass_cnt++;
        total_cnt++; if (we_xfer !== 1 || last_waddr !== 32'd4 || last_wdata !== 32'h55)
            $display("FAIL sw_xfer: got n=%0d addr=%h data=%h want 1 00000004 00000055", we_xfer, last_waddr, last_wdata);
        else pass_cnt++;
    endtask

    task automatic test_trap();
        apply_reset(0);
        mem['hC00] = ei(6'h2B, 5'd0, 5'd1, 16'd2);
        release_reset();
        run(3);
        total_cnt++; if (trap !== 1'b1 || pc !== 32'h3000 || mem_req !== 1'b0)
            $display("FAIL trap_sw: got trap=%b pc=%h req=%b want 1 00003000 0", trap, pc, mem_req);
        else pass_cnt++;
        run(6);
        total_cnt++; if (we_pulse !== 0 || trap !== 1'b1 || pc !== 32'h3000)
            $display("FAIL trap_hold: got we=%0d trap=%b pc=%h want 0 1 00003000", we_pulse, trap, pc);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (trap !== 1'b0 || pc !== 32'h3000)
            $display("FAIL trap_rst: got trap=%b pc=%h want 0 00003000", trap, pc);
        else pass_cnt++;
        mem['hC00] = 32'hFC000000;
        release_reset();
        run(2);
        total_cnt++; if (trap !== 1'b1 || pc !== 32'h3000)
            $display("FAIL bad_op: got trap=%b pc=%h want 1 00003000", trap, pc);
        else pass_cnt++;
        apply_reset(0);
        mem['hC00] = er(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F);
        release_reset();
        run(1);
        total_cnt++; if (trap !== 1'b0) $display("FAIL bad_fn_early: got %b want 0", trap); else pass_cnt++;
        run(1);
        total_cnt++; if (trap !== 1'b1) $display("FAIL bad_fn: got %b want 1", trap); else pass_cnt++;
    endtask

    task automatic test_r0();
        apply_reset(0);
        mem['hC00] = ei(6'h09, 5'd0, 5'd0, 16'd7);
        mem['hC01] = ei(6'h09, 5'd0, 5'd1, 16'd7);
        reg_sel = 5'd0;
        release_reset();
        run(4);
        total_cnt++; if (reg_data !== 32'd0 || pc !== 32'h3004)
            $display("FAIL r0_write: got r0=%h pc=%h want 0 00003004", reg_data, pc);
        else pass_cnt++;
        run(4);
        reg_sel = 5'd1;
        #1;
        total_cnt++; if (reg_data !== 32'd7) $display("FAIL r1_write: got %h want 7", reg_data); else pass_cnt++;
    endtask

`ifdef MCCPU_PERF_EN
    task automatic test_perf();
        apply_reset(0);
        for (int i = 0; i < 10; i++) mem['hC00 + i] = ei(6'h09, 5'd0, 5'(i + 1), 16'(i));
        mem['hC0A] = ei(6'h2B, 5'd0, 5'd1, 16'd1);
        #1;
        total_cnt++; if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0)
            $display("FAIL perf_rst: got %0d %0d want 0 0", cycle_cnt, instret_cnt);
        else pass_cnt++;
        release_reset();
        run(40);
        total_cnt++; if (instret_cnt !== 32'd10 || cycle_cnt !== 32'd40)
            $display("FAIL perf_cnt: got instret=%0d cycle=%0d want 10 40", instret_cnt, cycle_cnt);
        else pass_cnt++;
        run(8);
        total_cnt++; if (instret_cnt !== 32'd10 || cycle_cnt !== 32'd43)
            $display("FAIL perf_trap: got instret=%0d cycle=%0d want 10 43", instret_cnt, cycle_cnt);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_wait_lw();
        test_branch();
        test_jal_jr();
        test_sw();
        test_trap();
        test_r0();
`ifdef MCCPU_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
